// File: rtl/wb_assoc_cache.sv
// N-way set-associative write-back/write-allocate cache for 128-bit lines with tree-PLRU replacement.
// Optional saturating hit/miss counters are enabled by defining WB_ASSOC_CACHE_PERF_CNT_EN.
module wb_assoc_cache #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned SETS  = 8,
  parameter int unsigned ADR_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADR_W-1:0]   sb_adr,
  input  logic [127:0]       sb_dat_m,
  input  logic [15:0]        sb_sel,
  input  logic               sb_we,
  input  logic               sb_stb,
  input  logic               sb_cyc,
  output logic               sb_ack,
  output logic [127:0]       sb_dat_s,
  output logic [ADR_W-1:0]   wb_adr,
  output logic [127:0]       wb_dat_m,
  input  logic [127:0]       wb_dat_s,
  output logic               wb_we,
  output logic               wb_stb,
  output logic               wb_cyc,
  output logic [15:0]        wb_sel,
  input  logic               wb_ack,
  output logic               hit_pulse,
  output logic               miss_pulse
`ifdef WB_ASSOC_CACHE_PERF_CNT_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`endif
);

  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADR_W - IDX_W;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned BYTES  = 16;

  typedef enum logic [1:0] {IDLE, TAG_CHK, WRITEBACK, FILL} state_e;

  state_e state_q, state_d;

  logic [ADR_W-1:0]  req_adr;
  logic              req_we;
  logic [BYTES-1:0]  req_sel;
  logic [LINE_W-1:0] req_dat;
  logic              first_q;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;

  logic [LINE_W-1:0] data_q  [WAYS][SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   dirty_q [WAYS];
  logic [2:0]        plru_q  [SETS];
  logic [WAY_W-1:0]  victim_q;

  logic              hit_c;
  logic [WAY_W-1:0]  hit_way_c;
  logic [WAY_W-1:0]  victim_c;
  logic              victim_dirty_c;
  logic [LINE_W-1:0] hit_line_c;
  logic [LINE_W-1:0] merged_c;

  logic              sb_ack_d, hit_d, miss_d, wb_stb_d, wb_we_d;
  logic [ADR_W-1:0]  wb_adr_d;
  logic [LINE_W-1:0] wb_dat_m_d, sb_dat_s_d;

  assign req_idx = req_adr[IDX_W-1:0];
  assign req_tag = req_adr[ADR_W-1:IDX_W];
  assign wb_cyc  = wb_stb;
  assign wb_sel  = 16'hFFFF;

  // PLRU bits point toward the side to evict next: p[0] root, p[1] ways 0/1, p[2] ways 2/3.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [2:0] p);
    if (WAYS == 4)      return WAY_W'(p[0] ? {1'b1, p[2]} : {1'b0, p[1]});
    else if (WAYS == 2) return WAY_W'(p[0]);
    else                return '0;
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [WAY_W-1:0] w);
    logic [1:0] w2;
    logic [2:0] r;
    w2 = 2'(w);
    r  = p;
    if (WAYS == 4) begin
      r[0] = ~w2[1];
      if (w2[1]) r[2] = ~w2[0];
      else       r[1] = ~w2[0];
    end else if (WAYS == 2) begin
      r[0] = ~w2[0];
    end
    return r;
  endfunction

  // Lookup, byte merge and victim selection for the captured request.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    end
    hit_line_c = data_q[hit_way_c][req_idx];
    merged_c   = hit_line_c;
    for (int b = 0; b < int'(BYTES); b++) begin
      if (req_sel[b]) merged_c[8*b +: 8] = req_dat[8*b +: 8];
    end
    victim_c = plru_victim(plru_q[req_idx]);
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[w][req_idx]) victim_c = WAY_W'(w);
    end
    victim_dirty_c = valid_q[victim_c][req_idx] & dirty_q[victim_c][req_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (sb_stb && sb_cyc) state_d = TAG_CHK;
      TAG_CHK:   state_d = hit_c ? IDLE : (victim_dirty_c ? WRITEBACK : FILL);
      WRITEBACK: if (wb_ack) state_d = FILL;
      FILL:      if (wb_ack) state_d = TAG_CHK;
      default:   state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs.
  always_comb begin
    sb_ack_d   = 1'b0;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    sb_dat_s_d = sb_dat_s;
    wb_stb_d   = wb_stb;
    wb_we_d    = wb_we;
    wb_adr_d   = wb_adr;
    wb_dat_m_d = wb_dat_m;
    case (state_q)
      TAG_CHK: begin
        if (hit_c) begin
          sb_ack_d   = 1'b1;
          hit_d      = first_q;
          sb_dat_s_d = req_we ? merged_c : hit_line_c;
        end else begin
          miss_d   = first_q;
          wb_stb_d = 1'b1;
          if (victim_dirty_c) begin
            wb_we_d    = 1'b1;
            wb_adr_d   = {tag_q[victim_c][req_idx], req_idx};
            wb_dat_m_d = data_q[victim_c][req_idx];
          end else begin
            wb_we_d  = 1'b0;
            wb_adr_d = req_adr;
          end
        end
      end
      WRITEBACK: begin
        if (wb_ack) begin
          wb_we_d  = 1'b0;
          wb_adr_d = req_adr;
        end
      end
      FILL: begin
        if (wb_ack) wb_stb_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_ack     <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      sb_dat_s   <= '0;
      wb_stb     <= 1'b0;
      wb_we      <= 1'b0;
      wb_adr     <= '0;
      wb_dat_m   <= '0;
    end else begin
      sb_ack     <= sb_ack_d;
      hit_pulse  <= hit_d;
      miss_pulse <= miss_d;
      sb_dat_s   <= sb_dat_s_d;
      wb_stb     <= wb_stb_d;
      wb_we      <= wb_we_d;
      wb_adr     <= wb_adr_d;
      wb_dat_m   <= wb_dat_m_d;
    end
  end

  // Request capture; first_q marks the initial lookup so a refill re-lookup does not count twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_adr <= '0;
      req_we  <= 1'b0;
      req_sel <= '0;
      req_dat <= '0;
      first_q <= 1'b0;
    end else if (state_q == IDLE && sb_stb && sb_cyc) begin
      req_adr <= sb_adr;
      req_we  <= sb_we;
      req_sel <= sb_sel;
      req_dat <= sb_dat_m;
      first_q <= 1'b1;
    end else if (state_q == TAG_CHK) begin
      first_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '{default: '0};
      dirty_q  <= '{default: '0};
      plru_q   <= '{default: '0};
      victim_q <= '0;
    end else begin
      case (state_q)
        TAG_CHK: begin
          if (hit_c) begin
            plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way_c);
            if (req_we && (req_sel != '0)) dirty_q[hit_way_c][req_idx] <= 1'b1;
          end else begin
            victim_q <= victim_c;
          end
        end
        WRITEBACK: if (wb_ack) dirty_q[victim_q][req_idx] <= 1'b0;
        FILL: begin
          if (wb_ack) begin
            valid_q[victim_q][req_idx] <= 1'b1;
            dirty_q[victim_q][req_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag storage carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (state_q == TAG_CHK && hit_c && req_we) begin
      data_q[hit_way_c][req_idx] <= merged_c;
    end else if (state_q == FILL && wb_ack) begin
      data_q[victim_q][req_idx] <= wb_dat_s;
      tag_q[victim_q][req_idx]  <= req_tag;
    end
  end

`ifdef WB_ASSOC_CACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_pulse && (hit_cnt != 32'hFFFF_FFFF))   hit_cnt  <= hit_cnt + 32'd1;
      if (miss_pulse && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_assoc_cache.sv
// Directed bench for wb_assoc_cache (WAYS=2, SETS=8) with a behavioural memory responder.
module tb_wb_assoc_cache;

  logic         clk, rst_n;
  logic [11:0]  sb_adr;
  logic [127:0] sb_dat_m, sb_dat_s;
  logic [15:0]  sb_sel;
  logic         sb_we, sb_stb, sb_cyc, sb_ack;
  logic [11:0]  wb_adr;
  logic [127:0] wb_dat_m, wb_dat_s;
  logic         wb_we, wb_stb, wb_cyc, wb_ack;
  logic [15:0]  wb_sel;
  logic         hit_pulse, miss_pulse;
`ifdef WB_ASSOC_CACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  wb_assoc_cache dut (
    .clk(clk), .rst_n(rst_n),
    .sb_adr(sb_adr), .sb_dat_m(sb_dat_m), .sb_sel(sb_sel), .sb_we(sb_we),
    .sb_stb(sb_stb), .sb_cyc(sb_cyc), .sb_ack(sb_ack), .sb_dat_s(sb_dat_s),
    .wb_adr(wb_adr), .wb_dat_m(wb_dat_m), .wb_dat_s(wb_dat_s), .wb_we(wb_we),
    .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_sel(wb_sel), .wb_ack(wb_ack),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
`ifdef WB_ASSOC_CACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [127:0] mem [logic [11:0]];
  logic         mem_hold;
  int           log_n;
  logic         log_we  [32];
  logic [11:0]  log_adr [32];
  logic [127:0] log_dat [32];

  localparam logic [127:0] LINE_A5   = {16{8'hA5}};
  localparam logic [127:0] LINE_18   = {16{8'h18}};
  localparam logic [127:0] LINE_20   = {16{8'h20}};
  localparam logic [127:0] LINE_BEEF = {{14{8'hA5}}, 16'hBEEF};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Memory slave: acks one cycle after seeing a strobe, logs every transaction.
  initial begin
    wb_ack   = 1'b0;
    wb_dat_s = '0;
    log_n    = 0;
    forever begin
      @(negedge clk);
      if (wb_ack) begin
        wb_ack = 1'b0;
      end else if (wb_stb && wb_cyc && !mem_hold) begin
        if (log_n < 32) begin
          log_we[log_n]  = wb_we;
          log_adr[log_n] = wb_adr;
          log_dat[log_n] = wb_dat_m;
        end
        log_n++;
        if (wb_we) mem[wb_adr] = wb_dat_m;
        else       wb_dat_s = mem.exists(wb_adr) ? mem[wb_adr] : '0;
        wb_ack = 1'b1;
      end
    end
  end

  task automatic do_req(input logic [11:0] adr, input logic we, input logic [15:0] sel,
                        input logic [127:0] dat, output logic [127:0] rdat, output int cyc,
                        output logic hp, output logic mp);
    @(negedge clk);
    sb_adr = adr; sb_we = we; sb_sel = sel; sb_dat_m = dat;
    sb_stb = 1'b1; sb_cyc = 1'b1;
    cyc = 0; hp = 1'b0; mp = 1'b0; rdat = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (miss_pulse) mp = 1'b1;
      if (sb_ack) begin
        hp   = hit_pulse;
        rdat = sb_dat_s;
        break;
      end
    end
    chk("req_ack_seen", sb_ack, 1'b1);
    sb_stb = 1'b0; sb_cyc = 1'b0; sb_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  logic [127:0] rd;
  int           cyc, n0;
  logic         hp, mp;

  initial begin
    rst_n = 1'b0; mem_hold = 1'b0;
    sb_adr = '0; sb_dat_m = '0; sb_sel = '0; sb_we = 1'b0; sb_stb = 1'b0; sb_cyc = 1'b0;
    mem[12'h010] = LINE_A5;
    mem[12'h018] = LINE_18;
    mem[12'h020] = LINE_20;
    mem[12'h028] = {16{8'h28}};

    repeat (2) @(posedge clk); #1;
    chk("rst_sb_ack", sb_ack, 1'b0);
    chk("rst_hit_pulse", hit_pulse, 1'b0);
    chk("rst_miss_pulse", miss_pulse, 1'b0);
    chk("rst_wb_stb", wb_stb, 1'b0);
    chk("rst_wb_cyc", wb_cyc, 1'b0);
    chk("rst_wb_we", wb_we, 1'b0);
    chk("rst_wb_adr", wb_adr, 12'h000);
    chk("rst_wb_dat_m", wb_dat_m, '0);
    chk("rst_wb_sel", wb_sel, 16'hFFFF);
    @(negedge clk) rst_n = 1'b1;

    // Cold read miss then a re-read hit.
    n0 = log_n;
    do_req(12'h010, 1'b0, 16'h0, '0, rd, cyc, hp, mp);
    chk("s1_miss_pulse", mp, 1'b1);
    chk("s1_hit_pulse", hp, 1'b0);
    chk("s1_data", rd, LINE_A5);
    chk("s1_latency", cyc, 4);
    chk("s1_wb_count", log_n - n0, 1);
    chk("s1_wb_adr", log_adr[n0], 12'h010);
    chk("s1_wb_we", log_we[n0], 1'b0);
    n0 = log_n;
    do_req(12'h010, 1'b0, 16'h0, '0, rd, cyc, hp, mp);
    chk("s1_reread_hit", hp, 1'b1);
    chk("s1_reread_nomiss", mp, 1'b0);
    chk("s1_reread_latency", cyc, 2);
    chk("s1_reread_data", rd, LINE_A5);
    chk("s1_reread_no_wb", log_n - n0, 0);
`ifdef WB_ASSOC_CACHE_PERF_CNT_EN
    @(posedge clk); #1;
    chk("perf_hit_cnt", hit_cnt, 32'd1);
    chk("perf_miss_cnt", miss_cnt, 32'd1);
`endif

    // Byte-masked write hit.
    do_req(12'h010, 1'b1, 16'h0003, {112'h0, 16'hBEEF}, rd, cyc, hp, mp);
    chk("s2_write_hit", hp, 1'b1);
    chk("s2_write_latency", cyc, 2);
    do_req(12'h010, 1'b0, 16'h0, '0, rd, cyc, hp, mp);
    chk("s2_merged_data", rd, LINE_BEEF);

    // PLRU picks the clean, least-recently-used way.
    n0 = log_n;
    do_req(12'h010, 1'b0, 16'h0, '0, rd, cyc, hp, mp);
    do_req(12'h018, 1'b0, 16'h0, '0, rd, cyc, hp, mp);
    chk("s3_018_data", rd, LINE_18);
    do_req(12'h010, 1'b0, 16'h0, '0, rd, cyc, hp, mp);
    chk("s3_010_hit", hp, 1'b1);
    do_req(12'h020, 1'b0, 16'h0, '0, rd, cyc, hp, mp);
    chk("s3_020_miss", mp, 1'b1);
    chk("s3_020_data", rd, LINE_20);
    chk("s3_020_latency", cyc, 4);
    chk("s3_wb_count", log_n - n0, 2);
    chk("s3_020_we", log_we[n0+1], 1'b0);
    chk("s3_020_adr", log_adr[n0+1], 12'h020);

    // Dirty victim is written back before the fill.
    do_req(12'h010, 1'b0, 16'h0, '0, rd, cyc, hp, mp);
    do_req(12'h018, 1'b0, 16'h0, '0, rd, cyc, hp, mp);
    n0 = log_n;
    do_req(12'h020, 1'b0, 16'h0, '0, rd, cyc, hp, mp);
    chk("s4_miss", mp, 1'b1);
    chk("s4_latency", cyc, 6);
    chk("s4_wb_count", log_n - n0, 2);
    chk("s4_wb_we", log_we[n0], 1'b1);
    chk("s4_wb_adr", log_adr[n0], 12'h010);
    chk("s4_wb_dat", log_dat[n0], LINE_BEEF);
    chk("s4_fill_we", log_we[n0+1], 1'b0);
    chk("s4_fill_adr", log_adr[n0+1], 12'h020);
    chk("s4_data", rd, LINE_20);
    do_req(12'h010, 1'b0, 16'h0, '0, rd, cyc, hp, mp);
    chk("s4_reread_miss", mp, 1'b1);
    chk("s4_reread_data", rd, LINE_BEEF);

    // Zero byte-select write: acked, data and dirty untouched.
    do_req(12'h010, 1'b1, 16'h0000, '1, rd, cyc, hp, mp);
    chk("sel0_hit", hp, 1'b1);
    do_req(12'h010, 1'b0, 16'h0, '0, rd, cyc, hp, mp);
    chk("sel0_data", rd, LINE_BEEF);
    do_req(12'h018, 1'b0, 16'h0, '0, rd, cyc, hp, mp);
    n0 = log_n;
    do_req(12'h020, 1'b0, 16'h0, '0, rd, cyc, hp, mp);
    chk("sel0_clean_evict_count", log_n - n0, 1);
    chk("sel0_clean_evict_we", log_we[n0], 1'b0);

    // Reset while a fill is outstanding.
    mem_hold = 1'b1;
    @(negedge clk);
    sb_adr = 12'h028; sb_we = 1'b0; sb_sel = '0; sb_stb = 1'b1; sb_cyc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (wb_stb) break;
    end
    chk("rstfill_wb_stb", wb_stb, 1'b1);
    chk("rstfill_wb_we", wb_we, 1'b0);
    chk("rstfill_wb_adr", wb_adr, 12'h028);
    #2 rst_n = 1'b0; sb_stb = 1'b0; sb_cyc = 1'b0;
    #1;
    chk("rstfill_stb_low", wb_stb, 1'b0);
    chk("rstfill_cyc_low", wb_cyc, 1'b0);
`ifdef WB_ASSOC_CACHE_PERF_CNT_EN
    chk("perf_rst_hit_cnt", hit_cnt, 32'd0);
    chk("perf_rst_miss_cnt", miss_cnt, 32'd0);
`endif
    @(negedge clk);
    mem_hold = 1'b0;
    rst_n = 1'b1;
    do_req(12'h018, 1'b0, 16'h0, '0, rd, cyc, hp, mp);
    chk("post_rst_miss", mp, 1'b1);
    chk("post_rst_data", rd, LINE_18);
    do_req(12'h010, 1'b0, 16'h0, '0, rd, cyc, hp, mp);
    chk("post_rst_010_miss", mp, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
